// File: rtl/idli_pkg.sv
// Shared types and helpers for the idli core's nibble-serial datapath.
package idli_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [3:0] {
      EX_ADD   = 4'd0,
      EX_SUB   = 4'd1,
      EX_AND   = 4'd2,
      EX_OR    = 4'd3,
      EX_XOR   = 4'd4,
      EX_ANDN  = 4'd5,
      EX_LSL   = 4'd6,
      EX_CMPEQ = 4'd8,
      EX_CMPLT = 4'd9
   } idli_ex_op_t;

   // True for ops that write a result back through the A port.
   function automatic logic writes(input logic [3:0] op);
      logic w;
      case (op)
         EX_ADD, EX_SUB, EX_AND, EX_OR, EX_XOR, EX_ANDN, EX_LSL: w = 1'b1;
         default:                                                w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/idli_ex_nib_m.sv
// One-nibble combinational ALU slice; carry and shift bits are chained
// across beats by the sequencer in idli_ex_m.
module idli_ex_nib_m
   import idli_pkg::*;
(
   input  logic [3:0]          op_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic [NIBBLE_W-1:0] c_i,
   input  logic                cin_i,
   input  logic                sin_i,
   output logic [NIBBLE_W-1:0] res_o,
   output logic                cout_o
);

   logic [NIBBLE_W-1:0] c_opd_s;
   logic [NIBBLE_W:0]   sum_s;

   // Adder operand select (subtract and unsigned compare add the inverse) and op mux.
   always_comb begin
      c_opd_s = ((op_i == EX_SUB) || (op_i == EX_CMPLT)) ? ~c_i : c_i;
      sum_s   = {1'b0, b_i} + {1'b0, c_opd_s} + {{NIBBLE_W{1'b0}}, cin_i};
      res_o   = {NIBBLE_W{1'b0}};
      cout_o  = 1'b0;
      case (op_i)
         EX_ADD, EX_SUB, EX_CMPLT: begin
            res_o  = sum_s[NIBBLE_W-1:0];
            cout_o = sum_s[NIBBLE_W];
         end
         EX_AND:  res_o = b_i & c_i;
         EX_OR:   res_o = b_i | c_i;
         EX_XOR:  res_o = b_i ^ c_i;
         EX_ANDN: res_o = b_i & ~c_i;
         EX_LSL:  res_o = {b_i[NIBBLE_W-2:0], sin_i};
         default: begin
            res_o  = {NIBBLE_W{1'b0}};
            cout_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/idli_ex_m.sv
// Nibble-serial execute unit: consumes B/C operand nibbles LSB first and
// returns result nibbles on the A write port in the same cycle.
module idli_ex_m
   import idli_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                i_ex_gck,
   input  logic                i_ex_rst_n,
   input  logic                i_ex_start,
   input  logic [3:0]          i_ex_op,
   input  logic [2:0]          i_ex_dst,
   input  logic [NIBBLE_W-1:0] i_ex_b_data,
   input  logic [NIBBLE_W-1:0] i_ex_c_data,
   output logic                o_ex_busy,
   output logic [2:0]          o_ex_a,
   output logic                o_ex_a_vld,
   output logic [NIBBLE_W-1:0] o_ex_a_data,
   output logic                o_ex_flag,
   output logic                o_ex_flag_vld
);

   localparam int                BEAT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NIBBLES - 1);

   logic              active_q, active_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              carry_q, carry_d;
   logic              eq_q, eq_d;
   logic              sin_q, sin_d;
   logic [3:0]        op_q, op_d;
   logic [2:0]        dst_q, dst_d;
   logic              flag_q, flag_d;
   logic              flag_vld_q, flag_vld_d;

   logic                start_s, run_s, last_s;
   logic [3:0]          op_s;
   logic [2:0]          dst_s;
   logic                cin_s, sin_s, nib_eq_s, a_vld_s;
   logic [NIBBLE_W-1:0] res_s;
   logic                cout_s;

   // Beat 0 takes op/dst/carry/shift straight from the inputs; later beats use the latches.
   always_comb begin
      start_s  = i_ex_start & ~active_q;
      run_s    = start_s | active_q;
      last_s   = active_q & (beat_q == LAST_BEAT);
      op_s     = active_q ? op_q : i_ex_op;
      dst_s    = active_q ? dst_q : i_ex_dst;
      cin_s    = active_q ? carry_q : ((i_ex_op == EX_SUB) || (i_ex_op == EX_CMPLT));
      sin_s    = active_q ? sin_q : 1'b0;
      nib_eq_s = (i_ex_b_data == i_ex_c_data);
   end

   idli_ex_nib_m u_nib (
      .op_i   (op_s),
      .b_i    (i_ex_b_data),
      .c_i    (i_ex_c_data),
      .cin_i  (cin_s),
      .sin_i  (sin_s),
      .res_o  (res_s),
      .cout_o (cout_s)
   );

   // Sequencer and datapath state register.
   always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
      if (!i_ex_rst_n) begin
         active_q   <= 1'b0;
         beat_q     <= '0;
         carry_q    <= 1'b0;
         eq_q       <= 1'b1;
         sin_q      <= 1'b0;
         op_q       <= 4'd0;
         dst_q      <= 3'd0;
         flag_q     <= 1'b0;
         flag_vld_q <= 1'b0;
      end else begin
         active_q   <= active_d;
         beat_q     <= beat_d;
         carry_q    <= carry_d;
         eq_q       <= eq_d;
         sin_q      <= sin_d;
         op_q       <= op_d;
         dst_q      <= dst_d;
         flag_q     <= flag_d;
         flag_vld_q <= flag_vld_d;
      end
   end

   // Next-state: a start while busy is ignored; the last beat retires the op and resolves compares.
   always_comb begin
      active_d   = active_q;
      beat_d     = beat_q;
      carry_d    = carry_q;
      eq_d       = eq_q;
      sin_d      = sin_q;
      op_d       = op_q;
      dst_d      = dst_q;
      flag_d     = flag_q;
      flag_vld_d = 1'b0;
      if (start_s) begin
         active_d = (NIBBLES > 1);
         beat_d   = BEAT_W'(1);
         op_d     = i_ex_op;
         dst_d    = i_ex_dst;
         carry_d  = cout_s;
         sin_d    = i_ex_b_data[NIBBLE_W-1];
         eq_d     = nib_eq_s;
      end else if (active_q) begin
         carry_d = cout_s;
         sin_d   = i_ex_b_data[NIBBLE_W-1];
         eq_d    = eq_q & nib_eq_s;
         if (last_s) begin
            active_d = 1'b0;
            beat_d   = '0;
            if (op_q == EX_CMPEQ) begin
               flag_d     = eq_q & nib_eq_s;
               flag_vld_d = 1'b1;
            end else if (op_q == EX_CMPLT) begin
               flag_d     = ~cout_s;
               flag_vld_d = 1'b1;
            end else begin
               flag_d     = flag_q;
               flag_vld_d = 1'b0;
            end
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end else begin
         flag_vld_d = 1'b0;
      end
   end

   // Outputs: the write port is combinational so the register file captures it this edge.
   always_comb begin
      a_vld_s       = run_s & writes(op_s) & (dst_s != 3'd0);
      o_ex_busy     = active_q;
      o_ex_a_vld    = a_vld_s;
      o_ex_a        = a_vld_s ? dst_s : 3'd0;
      o_ex_a_data   = run_s ? res_s : {NIBBLE_W{1'b0}};
      o_ex_flag     = flag_q;
      o_ex_flag_vld = flag_vld_q;
   end

endmodule
